matrix_dot_unit: RTL and testbench



---
 rtl/matrix_dot_unit.sv | 123 ++++++++++++
 tb/tb_matrix_dot_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_dot_unit.sv
// Sequential dot-product engine wrapped around an external 8-bit signed multiplier.
// Define DOT_SAT_EN for a saturating result; otherwise the result wraps to 8 bits.
module matrix_dot_unit #(
    parameter int N     = 5,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       len,
    input  logic [8*N-1:0]   row_vec,
    input  logic [8*N-1:0]   col_vec,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [7:0]       mul_prod,
    input  logic             mul_ovf,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result,
    output logic             ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FEED = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0]              N_LEN   = 3'(N);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_W'(128);

    logic [1:0]              state;
    logic [2:0]              idx;
    logic [2:0]              len_r;
    logic [7:0]              row_r [N];
    logic [7:0]              col_r [N];
    logic signed [ACC_W-1:0] acc;
    logic                    sticky;
    logic                    done_r;

    logic [2:0]              len_eff;
    logic signed [ACC_W-1:0] prod_ext;
    logic                    acc_hi;
    logic                    acc_lo;
    logic [7:0]              res_val;

    always_comb begin
        len_eff  = (len > N_LEN) ? N_LEN : len;
        prod_ext = {{(ACC_W-8){mul_prod[7]}}, mul_prod};
        acc_hi   = (acc > ACC_MAX);
        acc_lo   = (acc < ACC_MIN);
`ifdef DOT_SAT_EN
        if (acc_hi)
            res_val = 8'h7f;
        else if (acc_lo)
            res_val = 8'h80;
        else
            res_val = acc[7:0];
`else
        res_val = acc[7:0];
`endif
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == FEED) begin
            mul_a = row_r[idx];
            mul_b = col_r[idx];
        end
    end

    assign busy = (state != IDLE);
    assign done = done_r;

    // result/ovf/done are registered while in DONE, so they present one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            len_r  <= '0;
            acc    <= '0;
            sticky <= 1'b0;
            done_r <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                row_r[i] <= '0;
                col_r[i] <= '0;
            end
        end else begin
            done_r <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            row_r[i] <= row_vec[8*i +: 8];
                            col_r[i] <= col_vec[8*i +: 8];
                        end
                        len_r  <= len_eff;
                        acc    <= '0;
                        sticky <= 1'b0;
                        idx    <= '0;
                        state  <= (len_eff == 3'd0) ? DONE : FEED;
                    end
                end
                FEED: begin
                    acc    <= acc + prod_ext;
                    sticky <= sticky | mul_ovf;
                    idx    <= idx + 3'd1;
                    if (idx == len_r - 3'd1)
                        state <= DONE;
                end
                DONE: begin
                    result <= res_val;
                    ovf    <= sticky | acc_hi | acc_lo;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_dot_unit.sv
// Scoreboard bench for matrix_dot_unit: driver pushes expected results, monitor checks on done.
module tb_matrix_dot_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  len = '0;
    logic [39:0] row_vec = '0;
    logic [39:0] col_vec = '0;
    logic [7:0]  mul_a, mul_b, mul_prod;
    logic        mul_ovf;
    logic        busy, done, ovf;
    logic [7:0]  result;

    int checks = 0;
    int errors = 0;
    bit force_mul = 1'b0;
    int mul_full;

    typedef struct {
        logic [7:0] r;
        logic       o;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    matrix_dot_unit #(.N(5), .ACC_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .row_vec(row_vec), .col_vec(col_vec),
        .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod), .mul_ovf(mul_ovf),
        .busy(busy), .done(done), .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Bench multiplier: saturating 8-bit signed product, or a forced value
    always_comb begin
        mul_full = int'($signed(mul_a)) * int'($signed(mul_b));
        mul_prod = mul_full[7:0];
        mul_ovf  = 1'b0;
        if (mul_full > 127) begin
            mul_prod = 8'h7f;
            mul_ovf  = 1'b1;
        end else if (mul_full < -128) begin
            mul_prod = 8'h80;
            mul_ovf  = 1'b1;
        end
        if (force_mul) begin
            mul_prod = 8'h80;
            mul_ovf  = 1'b1;
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    function automatic logic [39:0] pack5(input int e0, e1, e2, e3, e4);
        logic [39:0] v;
        v = {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
        return v;
    endfunction

    // Reference: sum of (saturated) element products, then form the 8-bit result
    function automatic void model(input int l, input logic [39:0] r, input logic [39:0] c,
                                  output exp_t e, output int neff);
        int sum, p;
        bit st;
        logic signed [7:0] a, b;
        neff = (l > 5) ? 5 : l;
        sum = 0;
        st = 1'b0;
        for (int i = 0; i < neff; i++) begin
            a = r[8*i +: 8];
            b = c[8*i +: 8];
            p = int'(a) * int'(b);
            if (p > 127) begin p = 127; st = 1'b1; end
            else if (p < -128) begin p = -128; st = 1'b1; end
            sum += p;
        end
`ifdef DOT_SAT_EN
        e.r = (sum > 127) ? 8'h7f : (sum < -128) ? 8'h80 : 8'(sum);
`else
        e.r = 8'(sum);
`endif
        e.o = st || (sum > 127) || (sum < -128);
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", int'(done), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", int'($signed(result)), int'($signed(mon_e.r)));
                chk("ovf", int'(ovf), int'(mon_e.o));
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic drive_start(input int l, input logic [39:0] r, input logic [39:0] c);
        len = 3'(l);
        row_vec = r;
        col_vec = c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL done_timeout actual=none expected=done within 20 cycles");
    endtask

    task automatic issue(input int l, input logic [39:0] r, input logic [39:0] c);
        exp_t e;
        int neff, k;
        model(l, r, c, e, neff);
        exp_q.push_back(e);
        drive_start(l, r, c);
        wait_done(k);
        chk("latency", k, neff + 2);
    endtask

    initial begin
        int k, cnt, l;
        logic [39:0] r, c;
        exp_t e;
        int neff;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({mul_a, mul_b, busy, done, result, ovf}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic timing with operand stepping
        r = pack5(1, 2, 3, 0, 0);
        c = pack5(4, 5, 6, 0, 0);
        model(3, r, c, e, neff);
        exp_q.push_back(e);
        drive_start(3, r, c);
        chk("pair0", int'({mul_a, mul_b}), 16'h0104);
        @(posedge clk); #1;
        chk("busy_feed", int'(busy), 1);
        chk("pair1", int'({mul_a, mul_b}), 16'h0205);
        @(posedge clk); #1;
        chk("pair2", int'({mul_a, mul_b}), 16'h0306);
        wait_done(k);
        chk("basic_latency", k, 3);
        chk("basic_result", int'(result), 32);

        issue(2, pack5(-3, -4, 0, 0, 0), pack5(5, -6, 0, 0, 0));
        chk("signed_result", int'(result), 9);
        issue(2, pack5(100, 100, 0, 0, 0), pack5(1, 1, 0, 0, 0));
`ifdef DOT_SAT_EN
        chk("ovf_result", int'($signed(result)), 127);
`else
        chk("ovf_result", int'($signed(result)), -56);
`endif

        // Multiplier-flag propagation with a forced product
        e.r = 8'h80;
        e.o = 1'b1;
        exp_q.push_back(e);
        force_mul = 1'b1;
        drive_start(1, pack5(64, 0, 0, 0, 0), pack5(2, 0, 0, 0, 0));
        wait_done(k);
        force_mul = 1'b0;
        chk("forced_latency", k, 3);

        issue(0, pack5(9, 9, 9, 9, 9), pack5(9, 9, 9, 9, 9));
        issue(7, pack5(1, 1, 1, 1, 1), pack5(1, 1, 1, 1, 1));
        chk("len7_clamped", int'(result), 5);

        // Start while busy must be ignored
        r = pack5(2, 2, 2, 2, 0);
        c = pack5(3, 3, 3, 3, 0);
        model(4, r, c, e, neff);
        exp_q.push_back(e);
        drive_start(4, r, c);
        @(negedge clk);
        len = 3'd2;
        row_vec = pack5(50, 50, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        chk("busy_start_latency", k, 4);
        repeat (6) @(negedge clk);
        chk("busy_start_result", int'(result), 24);

        // Reset during the second FEED cycle
        drive_start(5, pack5(1, 2, 3, 4, 5), pack5(1, 1, 1, 1, 1));
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("midop_reset_outputs", int'({mul_a, mul_b, busy, done, result, ovf}), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("no_done_after_reset", cnt, 0);

        for (int n = 0; n < 40; n++) begin
            l = int'($urandom_range(0, 7));
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 1) != 0) begin
                    r[8*i +: 8] = 8'($urandom_range(0, 255));
                    c[8*i +: 8] = 8'($urandom_range(0, 255));
                end else begin
                    r[8*i +: 8] = 8'(int'($urandom_range(0, 24)) - 12);
                    c[8*i +: 8] = 8'(int'($urandom_range(0, 24)) - 12);
                end
            end
            issue(l, r, c);
            if ($urandom_range(0, 1) != 0)
                repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
